// File: rtl/ffa2_post_combine.sv
// ---------------------------------------------------------------------------
// ffa2_post_combine
//
// Post-add/delay stage of a 2-parallel fast-FIR (FFA). Takes the outputs of
// the three half-length sub-filters (H0, H0+H1, H1) for one input beat and
// forms the two output phases:
//    Y0 = H0 + z^-1 * H1        (h1_dly is the previous beat's H1 output)
//    Y1 = (H0+H1) - H0 - H1
// Both results are saturated to DATA_W bits, written into a 4-entry sample
// FIFO and streamed out one sample per cycle, Y0 first.
//
// Ports:
//    clk        system clock, rising edge
//    reset      asynchronous active-low reset
//    en         global enable; when low all state holds and no transfers occur
//    flush      synchronous clear of the FIFO and the H1 delay register
//    in_valid   sub-filter outputs valid this cycle
//    in_ready   a beat can be accepted (room for two samples)
//    h0_in      signed H0 sub-filter output
//    h01_in     signed (H0+H1) sub-filter output
//    h1_in      signed H1 sub-filter output
//    out_valid  out_data holds a sample
//    out_ready  downstream accepts the sample
//    out_data   signed serial output sample (0 when the FIFO is empty)
//    sat_flag   sticky: some output saturated since the last clear
//    sat_clr    synchronous clear of sat_flag
// ---------------------------------------------------------------------------
module ffa2_post_combine #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] h0_in,
   input  logic [DATA_W-1:0] h01_in,
   input  logic [DATA_W-1:0] h1_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              sat_flag,
   input  logic              sat_clr
);

   // Two guard bits: the three-operand difference for Y1 needs both.
   localparam int EXT_W = DATA_W + 2;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [1:0]        wr_ptr;
   logic [1:0]        rd_ptr;
   logic [2:0]        count;
   logic [DATA_W-1:0] h1_dly;

   logic              accept;
   logic              pop;
   logic [EXT_W-1:0]  y0_raw;
   logic [EXT_W-1:0]  y1_raw;
   logic [DATA_W-1:0] y0_sat;
   logic [DATA_W-1:0] y1_sat;
   logic              y0_ovf;
   logic              y1_ovf;

   // Sign-extend a DATA_W operand to the guarded width.
   function automatic logic [EXT_W-1:0] sext(input logic [DATA_W-1:0] v);
      return {{(EXT_W-DATA_W){v[DATA_W-1]}}, v};
   endfunction

   // A guarded value fits DATA_W exactly when its top three bits agree.
   function automatic logic ovf(input logic [EXT_W-1:0] v);
      return !((v[EXT_W-1:DATA_W-1] == '0) || (v[EXT_W-1:DATA_W-1] == '1));
   endfunction

   function automatic logic [DATA_W-1:0] clamp(input logic [EXT_W-1:0] v);
      logic [DATA_W-1:0] r;
      if (!ovf(v))
         r = v[DATA_W-1:0];
      else if (v[EXT_W-1])
         r = {1'b1, {(DATA_W-1){1'b0}}};
      else
         r = {1'b0, {(DATA_W-1){1'b1}}};
      return r;
   endfunction

   // Handshake decode uses only registered count, never out_ready, so
   // in_ready carries no combinational path from the downstream side.
   assign in_ready  = en & reset & (count <= 3'd2);
   assign out_valid = en & (count != 3'd0);
   assign out_data  = (count != 3'd0) ? mem[rd_ptr] : '0;

   assign accept = en & in_valid & in_ready;
   assign pop    = en & out_valid & out_ready;

   // NOTE: every variable gets a value on every path through always_comb;
   // a branch that skipped an assignment would infer a latch.
   always_comb begin
      y0_raw = '0;
      y1_raw = '0;
      y0_raw = sext(h0_in) + sext(h1_dly);
      y1_raw = sext(h01_in) - sext(h0_in) - sext(h1_in);
   end

   assign y0_sat = clamp(y0_raw);
   assign y1_sat = clamp(y1_raw);
   assign y0_ovf = ovf(y0_raw);
   assign y1_ovf = ovf(y1_raw);

   // NOTE: sample storage carries no reset; out_data is forced to 0 while
   // the FIFO is empty, so stale contents are never observable.
   always_ff @(posedge clk) begin
      if (accept && !flush) begin
         mem[wr_ptr]        <= y0_sat;
         mem[wr_ptr + 2'd1] <= y1_sat;
      end
   end

   // NOTE: state registers use non-blocking assignments so every update in
   // this block sees the pre-edge values of count and the pointers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         h1_dly <= '0;
      end else if (flush) begin
         // Discards any same-cycle accept or pop.
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         h1_dly <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 2'd2;
            h1_dly <= h1_in;
         end
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;
         count <= count + (accept ? 3'd2 : 3'd0) - (pop ? 3'd1 : 3'd0);
      end
   end

   // Sticky saturation indicator; a saturating beat wins over sat_clr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         sat_flag <= 1'b0;
      else if (accept && !flush && (y0_ovf || y1_ovf))
         sat_flag <= 1'b1;
      else if (sat_clr)
         sat_flag <= 1'b0;
   end

endmodule

// File: tb/tb_ffa2_post_combine.sv
module tb_ffa2_post_combine;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] h0_in;
   logic [15:0] h01_in;
   logic [15:0] h1_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        sat_flag;
   logic        sat_clr;

   int total = 0;
   int bad   = 0;

   // Reference model state: expected output stream and previous H1 value.
   int exp_q[$];
   int m_prev = 0;

   ffa2_post_combine #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .h0_in     (h0_in),
      .h01_in    (h01_in),
      .h1_in     (h1_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sat_flag  (sat_flag),
      .sat_clr   (sat_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int sat16(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // FFA post-combine on one accepted beat, in plain integer arithmetic.
   task automatic model_push(input int h0, input int h01, input int h1);
      exp_q.push_back(sat16(h0 + m_prev));
      exp_q.push_back(sat16(h01 - h0 - h1));
      m_prev = h1;
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_prev = 0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until accepted (bounded wait).
   task automatic beat(input int h0, input int h01, input int h1);
      bit done = 0;
      h0_in    = h0[15:0];
      h01_in   = h01[15:0];
      h1_in    = h1[15:0];
      in_valid = 1'b1;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            model_push(h0, h01, h1);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) check("beat_accept_timeout", 0, 1);
   endtask

   task automatic drain(input string name);
      int n = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         cyc(1);
         n++;
      end
      cyc(1);
      check({name, "_drained"}, exp_q.size(), 0);
      check({name, "_empty_valid"}, int'(out_valid), 0);
   endtask

   function automatic int rnd16();
      case ($urandom_range(0, 3))
         0:       return 32767;
         1:       return -32768;
         default: return int'($signed(16'($urandom)));
      endcase
   endfunction

   // Monitor: every pop is compared against the scoreboard head.
   always @(negedge clk) begin
      if (reset && en && out_valid && out_ready) begin
         if (exp_q.size() == 0)
            check("unexpected_output", int'($signed(out_data)), -99999);
         else
            check("out_data", int'($signed(out_data)), exp_q.pop_front());
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit rnd_done;
      reset = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
      h0_in = '0; h01_in = '0; h1_in = '0; out_ready = 1'b0; sat_clr = 1'b0;

      // Reset state
      cyc(2);
      @(negedge clk);
      check("rst_in_ready",  int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data",  int'(out_data), 0);
      check("rst_sat_flag",  int'(sat_flag), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;

      // Basic: 100,150,60,5
      out_ready = 1'b1;
      beat(100, 300, 50);
      beat(10, 20, 5);
      drain("basic");
      check("basic_sat_flag", int'(sat_flag), 0);

      // Saturation with h1_dly=1000
      beat(0, 0, 1000);
      beat(32000, -32768, 32767);
      drain("sat");
      check("sat_set", int'(sat_flag), 1);
      sat_clr = 1'b1;
      cyc(1);
      sat_clr = 1'b0;
      check("sat_cleared", int'(sat_flag), 0);
      sat_clr = 1'b1;
      beat(0, 32767, -32768);
      check("sat_set_wins", int'(sat_flag), 1);
      sat_clr = 1'b0;
      drain("sat2");
      sat_clr = 1'b1;
      cyc(1);
      sat_clr = 1'b0;

      // Backpressure: fill to 4, third beat stalls
      out_ready = 1'b0;
      beat(rnd16(), rnd16(), rnd16());
      beat(rnd16(), rnd16(), rnd16());
      @(negedge clk);
      check("bp_full_in_ready",  int'(in_ready), 0);
      check("bp_full_out_valid", int'(out_valid), 1);
      @(posedge clk); #1;
      fork
         beat(rnd16(), rnd16(), rnd16());
         begin
            repeat (3) @(negedge clk);
            check("bp_stall_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain("bp");

      // Simultaneous accept and pop at count=2 -> 3
      out_ready = 1'b0;
      beat(rnd16(), rnd16(), rnd16());
      out_ready = 1'b1;
      beat(rnd16(), rnd16(), rnd16());
      out_ready = 1'b0;
      @(negedge clk);
      check("simul_cnt3_in_ready", int'(in_ready), 0);
      check("simul_cnt3_valid",    int'(out_valid), 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      cyc(1);
      out_ready = 1'b0;
      @(negedge clk);
      check("simul_cnt2_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      drain("simul");

      // Random traffic with random backpressure (pointer wrap)
      rnd_done = 0;
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               cyc($urandom_range(0, 2));
               beat(rnd16(), rnd16(), rnd16());
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      drain("rand");

      // en=0 holds, flush with count=3
      out_ready = 1'b0;
      beat(rnd16(), rnd16(), rnd16());
      beat(rnd16(), rnd16(), rnd16());
      out_ready = 1'b1;
      cyc(1);
      out_ready = 1'b0;
      en = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("en0_out_valid", int'(out_valid), 0);
         check("en0_in_ready",  int'(in_ready), 0);
      end
      @(posedge clk); #1;
      en = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      check("en1_out_valid", int'(out_valid), 1);
      check("en1_head_held", int'($signed(out_data)), exp_q[0]);
      @(posedge clk); #1;
      flush = 1'b1;
      cyc(1);
      flush = 1'b0;
      model_clear();
      @(negedge clk);
      check("flush_out_valid", int'(out_valid), 0);
      check("flush_out_data",  int'(out_data), 0);
      check("flush_in_ready",  int'(in_ready), 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      beat(7, 9, 1);
      drain("flush");

      // Async reset mid-operation with count=3
      out_ready = 1'b0;
      beat(rnd16(), rnd16(), rnd16());
      beat(rnd16(), rnd16(), rnd16());
      out_ready = 1'b1;
      cyc(1);
      out_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("arst_out_valid", int'(out_valid), 0);
      check("arst_in_ready",  int'(in_ready), 0);
      model_clear();
      cyc(2);
      reset = 1'b1;
      out_ready = 1'b1;
      beat(5, 5, 5);
      drain("arst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
